auction_seq: RTL and testbench
==============================

# auction_seq

Sequential, parametrised successor to the combinational auction block. Accepts 2^N unsigned W-bit bids serially over a valid/ready stream, tracks the highest and second-highest bid on the fly, and reports the winner index and clearing price. Supports first-price and second-price (Vickrey) modes. Gate count stays O(W) independent of bidder count, which makes it the preferred form for large N in garbled-circuit flows.

## Interface
- N, 2, log2 of bidder count; bidders indexed 0..2^N-1
- W, 16, bid width in bits, unsigned
- MODE, 0, 0 = first-price (price = highest bid), 1 = second-price (price = second-highest bid)

- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new auction; honoured in IDLE or DONE only
- bid_valid  input  1  bid_in carries the next bid
- bid_in  input  W  bid of bidder bid_idx, unsigned
- bid_ready  output  1  high in COLLECT; a bid is accepted when bid_valid && bid_ready
- bid_idx  output  N  index of the bidder whose bid is expected next
- done  output  1  one-cycle pulse when results become valid
- winning_bid  output  W  clearing price per MODE; registered
- winner  output  N  index of highest bidder; registered

## Operation
- FSM states: IDLE, COLLECT, DONE.
  - IDLE --start--> COLLECT; DONE --start--> COLLECT; COLLECT --last bid accepted--> DONE.
  - start in COLLECT ignored.
- Entering COLLECT clears: best = 0, second = 0, best_idx = 0, bid_idx = 0.
- On each accepted bid b at index i:
  - if b > best: second <= best, best <= b, best_idx <= i
  - else if b > second: second <= b
  - bid_idx increments, N-bit counter. Acceptance at bid_idx = 2^N-1 ends collection; the counter wraps to 0.
- Ties: the strict comparison keeps the lowest index as winner. For second-price, a tie at the top sets price = tied value.
- On transition to DONE:
  - winner <= best_idx
  - winning_bid <= best (MODE 0) or second (MODE 1), using the values after the final update
- All bids zero: winner 0, price 0.
- winner and winning_bid hold their values until the next transition to DONE. They do not change during a subsequent COLLECT.
- bid_valid outside COLLECT is ignored.

## Timing
- Reset values: state IDLE, bid_ready 0, bid_idx 0, done 0, winning_bid 0, winner 0. Internal best, second and best_idx are 0.
- start sampled high in cycle t: bid_ready is high from t+1.
- Exactly one bid is accepted per handshake cycle. Bubbles (bid_valid low) stall without side effects.
- Last bid accepted in cycle t:
  - done = 1 and results valid in t+1
  - done = 0 in t+2 unless re-triggered
  - bid_ready = 0 from t+1
- Minimum auction length is 2^N + 1 cycles from start to done.
- start in the same cycle done is high (state DONE): new auction begins and results stay held.
- rst mid-COLLECT: next cycle is IDLE with all outputs at reset values. Partial bids are discarded.
- rst has priority over start and bid_valid in the same cycle.

## Structure
- Shared package auction_pkg:
  - state enum (IDLE, COLLECT, DONE)
  - MODE constants (AUCTION_FIRST_PRICE = 0, AUCTION_SECOND_PRICE = 1)
- One sub-module, auction_cmp_update:
  - purely combinational, parametrised by W and N
  - inputs (b, i, best, second, best_idx); outputs next best, second, best_idx
  - holds the compare/tie rule in one place for reuse by a future tree variant
- Top level holds the FSM, counter and output registers.

## Test plan
- N=2, W=16, MODE=0; bids 10, 40, 25, 5 with no bubbles -> done in cycle 5 after start; winner=1, winning_bid=40.
- Same bids, MODE=1 -> winner=1, winning_bid=25.
- MODE=1; bids 30, 50, 50, 20 -> winner=1 (lowest index wins the tie), winning_bid=50. Also all-zero bids -> winner=0, winning_bid=0.
- MODE=0; bids 0xFFFF, 1, 2, 3 with bid_valid low on alternate cycles -> bid_idx advances only on handshake; winner=0, winning_bid=0xFFFF; done exactly 1 cycle after the 4th accept.
- rst asserted after 2 accepted bids -> next cycle IDLE, bid_ready=0, outputs 0. A fresh start with bids 1, 2, 3, 4 (MODE=0) -> winner=3, winning_bid=4.
- Hold and restart:
  - After done, results hold through a second auction's COLLECT.
  - start asserted together with done, then bids 7, 7, 7, 7 (MODE=1) -> winner=0, winning_bid=7.
  - N=3, W=32 with eight random bids: results match the reference model.

Source files
------------

// File: rtl/auction_pkg.sv
// Shared types and constants for the serial sealed-bid auction.
// Pricing-mode encodings and the FSM state type live here so all files agree.
package auction_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } auction_state_e;

    localparam int AUCTION_FIRST_PRICE  = 0;
    localparam int AUCTION_SECOND_PRICE = 1;

endpackage

// File: rtl/auction_seq_if.sv
// Bid stream between a bid source (master) and the auction engine (slave).
// bid_idx tells the source which bidder's bid is expected next.
interface auction_seq_if #(
    parameter int N = 2,
    parameter int W = 16
);
    logic         bid_valid;
    logic [W-1:0] bid_in;
    logic         bid_ready;
    logic [N-1:0] bid_idx;

    modport master (output bid_valid, bid_in, input bid_ready, bid_idx);
    modport slave  (input bid_valid, bid_in, output bid_ready, bid_idx);
endinterface

// File: rtl/auction_cmp_update.sv
// One running-max step: folds bid b of bidder i into (best, second, best_idx).
// Strict comparisons keep the lowest index on ties and let a tied top bid set second.
module auction_cmp_update #(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic [W-1:0] b,
    input  logic [N-1:0] i,
    input  logic [W-1:0] best,
    input  logic [W-1:0] second,
    input  logic [N-1:0] best_idx,
    output logic [W-1:0] best_next,
    output logic [W-1:0] second_next,
    output logic [N-1:0] best_idx_next
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (b > best) begin
            second_next   = best;
            best_next     = b;
            best_idx_next = i;
        end else if (b > second) begin
            second_next = b;
        end
    end

endmodule

// File: rtl/auction_seq.sv
// Serial auction over 2^N bidders: collects one bid per handshake, tracks the
// top two bids, and publishes winner and clearing price with a one-cycle done pulse.
module auction_seq
    import auction_pkg::*;
#(
    parameter int N    = 2,
    parameter int W    = 16,
    parameter int MODE = AUCTION_FIRST_PRICE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    auction_seq_if.slave  bid,
    output logic          done,
    output logic [W-1:0]  winning_bid,
    output logic [N-1:0]  winner
);

    localparam logic [N-1:0] IDX_LAST = '1;
    localparam logic [N-1:0] IDX_ONE  = 1;

    auction_state_e state, state_next;

    logic [W-1:0] best, second, best_n, second_n;
    logic [N-1:0] best_idx, best_idx_n, idx;
    logic         ready;
    logic         accept, last_accept, begin_auction;

    assign accept        = (state == COLLECT) && bid.bid_valid;
    assign last_accept   = accept && (idx == IDX_LAST);
    assign begin_auction = start && (state != COLLECT);

    auction_cmp_update #(.W(W), .N(N)) u_cmp (
        .b            (bid.bid_in),
        .i            (idx),
        .best         (best),
        .second       (second),
        .best_idx     (best_idx),
        .best_next    (best_n),
        .second_next  (second_n),
        .best_idx_next(best_idx_n)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)       state_next = COLLECT;
            COLLECT: if (last_accept) state_next = DONE;
            DONE:    if (start)       state_next = COLLECT;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == COLLECT);
    end

    assign bid.bid_ready = ready;
    assign bid.bid_idx   = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            best        <= '0;
            second      <= '0;
            best_idx    <= '0;
            idx         <= '0;
            done        <= 1'b0;
            winning_bid <= '0;
            winner      <= '0;
        end else begin
            done <= last_accept;
            if (begin_auction) begin
                best     <= '0;
                second   <= '0;
                best_idx <= '0;
                idx      <= '0;
            end else if (accept) begin
                best     <= best_n;
                second   <= second_n;
                best_idx <= best_idx_n;
                idx      <= idx + IDX_ONE;
            end
            // Results are taken from the post-update values of the final bid.
            if (last_accept) begin
                winner      <= best_idx_n;
                winning_bid <= (MODE == AUCTION_SECOND_PRICE) ? second_n : best_n;
            end
        end
    end

endmodule

// File: tb/tb_auction_seq.sv
// Scoreboard bench: first- and second-price N=2 engines share one bid stream,
// plus an N=3/W=32 second-price engine checked against a reference model.
module tb_auction_seq;
    import auction_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_c;
    logic        bid_valid;
    logic [15:0] bid_in;

    auction_seq_if #(.N(2), .W(16)) if_fp ();
    auction_seq_if #(.N(2), .W(16)) if_sp ();
    auction_seq_if #(.N(3), .W(32)) if_c ();

    assign if_fp.bid_valid = bid_valid;
    assign if_fp.bid_in    = bid_in;
    assign if_sp.bid_valid = bid_valid;
    assign if_sp.bid_in    = bid_in;

    logic        done_fp, done_sp, done_c;
    logic [15:0] wb_fp, wb_sp;
    logic [31:0] wb_c;
    logic [1:0]  win_fp, win_sp;
    logic [2:0]  win_c;

    auction_seq #(.N(2), .W(16), .MODE(AUCTION_FIRST_PRICE)) dut_fp (
        .clk(clk), .rst(rst), .start(start), .bid(if_fp.slave),
        .done(done_fp), .winning_bid(wb_fp), .winner(win_fp));

    auction_seq #(.N(2), .W(16), .MODE(AUCTION_SECOND_PRICE)) dut_sp (
        .clk(clk), .rst(rst), .start(start), .bid(if_sp.slave),
        .done(done_sp), .winning_bid(wb_sp), .winner(win_sp));

    auction_seq #(.N(3), .W(32), .MODE(AUCTION_SECOND_PRICE)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bid(if_c.slave),
        .done(done_c), .winning_bid(wb_c), .winner(win_c));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] price;
        logic [2:0]  win;
    } exp_t;

    exp_t q_fp[$];
    exp_t q_sp[$];
    exp_t q_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: done pulsed with no expected result queued at %0t", name, $time);
    endtask

    // Monitor: pops one expected result per done pulse, independent of the driver.
    always @(negedge clk) begin
        exp_t e;
        if (done_fp) begin
            if (q_fp.size() == 0) report_unexpected("fp_done");
            else begin
                e = q_fp.pop_front();
                check("fp_winner", 32'(win_fp), 32'(e.win));
                check("fp_price", 32'(wb_fp), e.price);
            end
        end
        if (done_sp) begin
            if (q_sp.size() == 0) report_unexpected("sp_done");
            else begin
                e = q_sp.pop_front();
                check("sp_winner", 32'(win_sp), 32'(e.win));
                check("sp_price", 32'(wb_sp), e.price);
            end
        end
        if (done_c) begin
            if (q_c.size() == 0) report_unexpected("c_done");
            else begin
                e = q_c.pop_front();
                check("c_winner", 32'(win_c), 32'(e.win));
                check("c_price", wb_c, e.price);
            end
        end
    end

    task automatic expect_n2(input logic [1:0] wf, input logic [15:0] pf,
                             input logic [1:0] ws, input logic [15:0] ps);
        exp_t e;
        e.win = 3'(wf); e.price = 32'(pf); q_fp.push_back(e);
        e.win = 3'(ws); e.price = 32'(ps); q_sp.push_back(e);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_after_start", 32'(if_fp.bid_ready), 32'd1);
        check("idx_after_start", 32'(if_fp.bid_idx), 32'd0);
    endtask

    // Drives four bids; bids[0] is bidder 0. Leaves the bench in the done cycle.
    task automatic feed_n2(input logic [3:0][15:0] bids, input bit gaps, input bit hold_chk,
                           input logic [1:0] hold_w, input logic [15:0] hold_pf,
                           input logic [15:0] hold_ps);
        for (int k = 0; k < 4; k++) begin
            if (gaps && k > 0) begin
                bid_valid = 1'b0;
                bid_in    = 16'hDEAD;
                @(posedge clk); #1;
                check("idx_stalls_on_bubble", 32'(if_fp.bid_idx), 32'(k));
            end
            bid_valid = 1'b1;
            bid_in    = bids[k];
            check("ready_in_collect", 32'(if_sp.bid_ready), 32'd1);
            check("idx_fp", 32'(if_fp.bid_idx), 32'(k));
            check("idx_sp", 32'(if_sp.bid_idx), 32'(k));
            check("no_early_done", 32'(done_fp), 32'd0);
            if (hold_chk) begin
                check("hold_fp_winner", 32'(win_fp), 32'(hold_w));
                check("hold_fp_price", 32'(wb_fp), 32'(hold_pf));
                check("hold_sp_price", 32'(wb_sp), 32'(hold_ps));
            end
            @(posedge clk); #1;
        end
        bid_valid = 1'b0;
        check("done_fp_after_last", 32'(done_fp), 32'd1);
        check("done_sp_after_last", 32'(done_sp), 32'd1);
        check("ready_low_in_done", 32'(if_fp.bid_ready), 32'd0);
        check("idx_wrapped", 32'(if_fp.bid_idx), 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_is_pulse", 32'(done_fp), 32'd0);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_ready"}, 32'(if_fp.bid_ready), 32'd0);
        check({tag, "_idx"}, 32'(if_fp.bid_idx), 32'd0);
        check({tag, "_done"}, 32'(done_fp), 32'd0);
        check({tag, "_fp_winner"}, 32'(win_fp), 32'd0);
        check({tag, "_fp_price"}, 32'(wb_fp), 32'd0);
        check({tag, "_sp_winner"}, 32'(win_sp), 32'd0);
        check({tag, "_sp_price"}, 32'(wb_sp), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cb [8];
        int          w;
        logic [31:0] sec;
        exp_t        ec;

        rst = 1'b1; start = 1'b0; start_c = 1'b0;
        bid_valid = 1'b0; bid_in = '0;
        if_c.bid_valid = 1'b0; if_c.bid_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_reset("reset");
        check("reset_c_ready", 32'(if_c.bid_ready), 32'd0);
        check("reset_c_price", wb_c, 32'd0);
        rst = 1'b0;

        // 10, 40, 25, 5
        expect_n2(2'd1, 16'd40, 2'd1, 16'd25);
        start_pulse();
        feed_n2({16'd5, 16'd25, 16'd40, 16'd10}, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
        idle_cycle();

        // Tie at the top: lowest index wins, second price equals tied value.
        expect_n2(2'd1, 16'd50, 2'd1, 16'd50);
        start_pulse();
        feed_n2({16'd20, 16'd50, 16'd50, 16'd30}, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
        idle_cycle();

        expect_n2(2'd0, 16'd0, 2'd0, 16'd0);
        start_pulse();
        feed_n2('0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
        idle_cycle();

        // Maximum value first, with bubbles between bids.
        expect_n2(2'd0, 16'hFFFF, 2'd0, 16'd3);
        start_pulse();
        feed_n2({16'd3, 16'd2, 16'd1, 16'hFFFF}, 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
        idle_cycle();

        // Reset after two accepted bids, with start and bid_valid also high.
        start_pulse();
        bid_valid = 1'b1; bid_in = 16'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idx_before_rst", 32'(if_fp.bid_idx), 32'd2);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; bid_valid = 1'b0;
        check_outputs_reset("mid_rst");
        @(posedge clk); #1;
        check("still_idle_after_rst", 32'(if_fp.bid_ready), 32'd0);

        expect_n2(2'd3, 16'd4, 2'd3, 16'd3);
        start_pulse();
        feed_n2({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);

        // start in the done cycle; previous results must hold through COLLECT.
        expect_n2(2'd0, 16'd7, 2'd0, 16'd7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_ready", 32'(if_fp.bid_ready), 32'd1);
        check("restart_done_low", 32'(done_fp), 32'd0);
        feed_n2({16'd7, 16'd7, 16'd7, 16'd7}, 1'b0, 1'b1, 2'd3, 16'd4, 16'd3);
        idle_cycle();

        // N=3, W=32 second-price engine against a reference model.
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 8; j++) cb[j] = $urandom;
            if (r == 1) begin
                cb[1] = 32'hF000_0000 | $urandom;
                cb[6] = cb[1];
            end
            w = 0;
            for (int j = 1; j < 8; j++) if (cb[j] > cb[w]) w = j;
            sec = '0;
            for (int j = 0; j < 8; j++) if (j != w && cb[j] > sec) sec = cb[j];
            ec.win = 3'(w); ec.price = sec;
            q_c.push_back(ec);

            start_c = 1'b1;
            @(posedge clk); #1;
            start_c = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if_c.bid_valid = 1'b1;
                if_c.bid_in    = cb[j];
                check("c_idx", 32'(if_c.bid_idx), 32'(j));
                @(posedge clk); #1;
            end
            if_c.bid_valid = 1'b0;
            check("c_done_after_last", 32'(done_c), 32'd1);
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("fp_queue_drained", 32'(q_fp.size()), 32'd0);
        check("sp_queue_drained", 32'(q_sp.size()), 32'd0);
        check("c_queue_drained", 32'(q_c.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
